// File: rtl/lcd_dma.sv
// Byte-copy engine feeding the LCD frame buffer: streams bytes from the CPU
// address space into the 13-bit VRAM write port while stalling the CPU.
module lcd_dma #(
    parameter int LEN_UNIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        reg_we,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_din,
    output logic [12:0] vram_addr,
    output logic        vram_wr,
    output logic [7:0]  vram_dout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] src_q;
    logic [12:0] dst_q;
    logic [7:0]  len_q;
    logic [15:0] cur_src;
    logic [12:0] cur_dst;
    logic [12:0] remaining;
    logic [12:0] xfer_len;
    logic        wr_en;
    logic        start;
    logic        last;

    // Register writes are only honoured while idle, start included.
    assign wr_en    = ce & reg_we & (state == IDLE);
    assign start    = wr_en & (reg_addr == 3'd5) & reg_din[7];
    assign last     = (state == WRITE) & (remaining == 13'd1);
    assign xfer_len = 13'(((len_q == 8'd0) ? 32'd256 : 32'(len_q)) * LEN_UNIT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (ce) state_nx = WRITE;
            WRITE:   if (ce) state_nx = last ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        src_rd   = (state == READ);
        src_addr = src_rd ? cur_src : 16'h0000;
        vram_wr  = (state == WRITE) & ce;
    end

    always_comb begin
        reg_dout = 8'h00;
        unique case (reg_addr)
            3'd0:    reg_dout = src_q[7:0];
            3'd1:    reg_dout = src_q[15:8];
            3'd2:    reg_dout = dst_q[7:0];
            3'd3:    reg_dout = {3'b000, dst_q[12:8]};
            3'd4:    reg_dout = len_q;
            3'd5:    reg_dout = {busy, 7'b0};
            default: reg_dout = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            vram_addr <= '0;
            vram_dout <= '0;
            done      <= 1'b0;
        end else begin
            done <= ce & last;
            if (wr_en) begin
                unique case (reg_addr)
                    3'd0:    src_q[7:0]  <= reg_din;
                    3'd1:    src_q[15:8] <= reg_din;
                    3'd2:    dst_q[7:0]  <= reg_din;
                    3'd3:    dst_q[12:8] <= reg_din[4:0];
                    3'd4:    len_q       <= reg_din;
                    default: ;
                endcase
            end
            if (start) begin
                cur_src   <= src_q;
                cur_dst   <= dst_q;
                remaining <= xfer_len;
            end
            // The VRAM outputs double as the data latch and hold between strobes.
            if (ce && state == READ) begin
                vram_addr <= cur_dst;
                vram_dout <= src_din;
            end
            if (ce && state == WRITE) begin
                cur_src   <= cur_src + 16'd1;
                cur_dst   <= cur_dst + 13'd1;
                remaining <= remaining - 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_dma.sv
// Self-checking bench for lcd_dma: register table, reference-model copies,
// wrap-around, LEN=0, ignored writes, ce gating and mid-transfer reset.
module tb_lcd_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [7:0]  reg_din = 8'h00;
    logic [7:0]  reg_dout;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_din;
    logic [12:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_dout;
    logic        busy;
    logic        done;

    lcd_dma #(.LEN_UNIT(16)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
        .reg_dout(reg_dout), .src_addr(src_addr), .src_rd(src_rd),
        .src_din(src_din), .vram_addr(vram_addr), .vram_wr(vram_wr),
        .vram_dout(vram_dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ce_div = 1;
    int ce_cnt = 0;
    bit ce_rand = 1'b0;
    int done_cnt = 0;
    int busy_steps = 0;
    logic [20:0] wq[$];
    logic [15:0] sq[$];

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always_comb src_din = mem(src_addr);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ce_rand) begin
            ce = 1'($urandom_range(0, 1));
        end else begin
            ce_cnt = (ce_cnt + 1) % ce_div;
            ce = (ce_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (vram_wr) begin
            wq.push_back({vram_addr, vram_dout});
            chk("vram_wr_needs_ce", 32'(ce), 32'd1);
        end
        if (src_rd && ce) sq.push_back(src_addr);
        if (done) done_cnt++;
        if (busy && ce) busy_steps++;
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        int n;
        reg_we = 1'b1;
        reg_addr = a;
        reg_din = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ce && n < 100);
        @(posedge clk);
        #1;
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        reg_addr = a;
        #1;
        v = reg_dout;
    endtask

    task automatic run_xfer(input logic [15:0] s, input logic [12:0] d,
                            input logic [7:0] l, input bit poke);
        int n;
        int nb;
        int bad_w;
        int bad_s;
        logic [7:0] v;
        logic [20:0] ew;
        wq.delete();
        sq.delete();
        done_cnt = 0;
        busy_steps = 0;
        wr(3'd0, s[7:0]);
        wr(3'd1, s[15:8]);
        wr(3'd2, d[7:0]);
        wr(3'd3, {3'b111, d[12:8]});
        wr(3'd4, l);
        wr(3'd5, 8'h80);
        chk("busy_after_start", 32'(busy), 32'd1);
        if (poke) begin
            wr(3'd0, 8'hAA);
            wr(3'd1, 8'hAA);
            wr(3'd5, 8'h80);
            chk("busy_during_poke", 32'(busy), 32'd1);
        end
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_terminates", 32'(busy), 32'd0);
        chk("done_with_busy_fall", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        nb = ((l == 8'd0) ? 256 : int'(l)) * 16;
        chk("write_count", wq.size(), nb);
        chk("read_count", sq.size(), nb);
        chk("busy_steps", busy_steps, 2 * nb);
        chk("done_count", done_cnt, 1);
        bad_w = 0;
        bad_s = 0;
        for (int i = 0; i < nb && i < wq.size() && i < sq.size(); i++) begin
            ew = {13'(d + 13'(i)), mem(16'(s + 16'(i)))};
            if (wq[i] !== ew) bad_w++;
            if (sq[i] !== 16'(s + 16'(i))) bad_s++;
        end
        chk("write_seq_errors", bad_w, 0);
        chk("read_seq_errors", bad_s, 0);
        rd(3'd0, v); chk("reg0_kept", v, s[7:0]);
        rd(3'd1, v); chk("reg1_kept", v, s[15:8]);
        rd(3'd2, v); chk("reg2_kept", v, d[7:0]);
        rd(3'd3, v); chk("reg3_kept", v, {3'b000, d[12:8]});
        rd(3'd4, v); chk("reg4_kept", v, l);
        rd(3'd5, v); chk("reg5_idle", v, 8'h00);
    endtask

    typedef struct {
        bit         we;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
        bit         exp_busy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] v;
        int n;

        tbl[0] = '{1'b1, 3'd0, 8'h12, 8'h12, 1'b0};
        tbl[1] = '{1'b1, 3'd1, 8'h34, 8'h34, 1'b0};
        tbl[2] = '{1'b1, 3'd2, 8'hCD, 8'hCD, 1'b0};
        tbl[3] = '{1'b1, 3'd3, 8'hFF, 8'h1F, 1'b0};
        tbl[4] = '{1'b1, 3'd4, 8'h07, 8'h07, 1'b0};
        tbl[5] = '{1'b1, 3'd5, 8'h7F, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 3'd6, 8'h55, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 3'd7, 8'h55, 8'h00, 1'b0};
        tbl[8] = '{1'b0, 3'd0, 8'h00, 8'h12, 1'b0};

        // Reset with ce toggling
        ce_rand = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_vram_wr", 32'(vram_wr), 32'd0);
        chk("rst_src_rd", 32'(src_rd), 32'd0);
        chk("rst_src_addr", 32'(src_addr), 32'd0);
        chk("rst_vram_addr", 32'(vram_addr), 32'd0);
        chk("rst_vram_dout", 32'(vram_dout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), v);
            chk($sformatf("rst_reg%0d", i), v, 8'h00);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        ce_rand = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Register table, including CTRL=0x7F not starting
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].din);
            rd(tbl[i].addr, v);
            chk($sformatf("tbl%0d_dout", i), v, tbl[i].exp);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end
        repeat (3) @(negedge clk);
        chk("ctrl_7f_no_start", 32'(busy), 32'd0);
        @(posedge clk);
        #2;

        // Basic copy, full-rate then 1-in-4 ce
        run_xfer(16'h1234, 13'h0100, 8'd1, 1'b0);
        ce_div = 4;
        run_xfer(16'h1234, 13'h0100, 8'd1, 1'b0);
        ce_div = 1;

        // Wrap-around of both address spaces
        run_xfer(16'hFFF8, 13'h1FF8, 8'd1, 1'b0);

        // Writes while busy are ignored
        run_xfer(16'h4321, 13'h0A00, 8'd1, 1'b1);

        // LEN=0 means 4096 bytes
        run_xfer(16'h0000, 13'h0000, 8'd0, 1'b0);

        // Randomized transfers under random ce
        ce_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_xfer(16'($urandom), 13'($urandom), 8'($urandom_range(1, 3)), 1'b0);
        end
        ce_rand = 1'b0;
        ce_div = 4;

        // Reset after the 5th VRAM write
        wq.delete();
        done_cnt = 0;
        wr(3'd0, 8'h34);
        wr(3'd1, 8'h12);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h80);
        n = 0;
        while (wq.size() < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_5_writes", wq.size(), 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vram_wr", 32'(vram_wr), 32'd0);
        chk("midrst_vram_addr", 32'(vram_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd(3'(i), v);
            chk($sformatf("midrst_reg%0d", i), v, 8'h00);
        end
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_6th_write", wq.size(), 5);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
